// File: rtl/reduce_and_arb_pkg.sv
// Shared types and constants for the reduce_and_arbiter slice.
package reduce_and_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int OPS = 8;

  // A single requester still needs a 1-bit id field.
  function automatic int id_width(input int port_num);
    return (port_num > 1) ? $clog2(port_num) : 1;
  endfunction

endpackage

// File: rtl/reduce_and8.sv
// Combinational 8-operand reduction AND; the result lands in bit 0, upper bits are zero.
module reduce_and8 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  output logic [WIDTH-1:0] q
);

  // Zero-extend the single reduction bit.
  always_comb begin
    q    = '0;
    q[0] = &{a, b, c, d, e, f, g, h};
  end

endmodule

// File: rtl/reduce_and_arbiter.sv
// Arbitrates PORT_NUM requesters onto one registered 8-operand reduction-AND unit.
// Define REDUCE_AND_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module reduce_and_arbiter
  import reduce_and_arb_pkg::*;
#(
  parameter int  PORT_NUM = 2,
  parameter int  WIDTH    = 8,
  localparam int ID_W     = id_width(PORT_NUM)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PORT_NUM-1:0]           req_valid,
  output logic [PORT_NUM-1:0]           req_ready,
  input  logic [PORT_NUM*OPS*WIDTH-1:0] req_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [WIDTH-1:0]              rsp_q,
  output logic [ID_W-1:0]               rsp_id
);

  localparam int OPW = OPS * WIDTH;

  state_t              state_r;
  logic [OPW-1:0]      ops_r;
  logic [ID_W-1:0]     op_id_r;
  logic [ID_W-1:0]     ptr_s;
  logic                grant_any_s;
  logic [ID_W-1:0]     grant_idx_s;
  logic [PORT_NUM-1:0] grant_oh_s;
  logic [OPW-1:0]      grant_data_s;
  logic [WIDTH-1:0]    red_q_s;
  int                  cand_s;

`ifdef REDUCE_AND_ARB_RR_EN
  logic [ID_W-1:0] ptr_r;
  assign ptr_s = ptr_r;
`else
  assign ptr_s = '0;
`endif

  // Priority search from ptr_s upward with wrap; scanning high-to-low lets the nearest port win last.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = 0;
    for (int k = PORT_NUM - 1; k >= 0; k--) begin
      cand_s      = int'(ptr_s) + k;
      cand_s      = (cand_s >= PORT_NUM) ? (cand_s - PORT_NUM) : cand_s;
      grant_any_s = grant_any_s | req_valid[cand_s];
      grant_idx_s = req_valid[cand_s] ? ID_W'(cand_s) : grant_idx_s;
    end
  end

  // One-hot grant and the winner's operand bundle.
  always_comb begin
    grant_oh_s   = '0;
    grant_data_s = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      grant_oh_s[p] = grant_any_s && (grant_idx_s == ID_W'(p));
      grant_data_s  = grant_data_s | (grant_oh_s[p] ? req_data[p*OPW +: OPW] : {OPW{1'b0}});
    end
  end

  assign req_ready = ((state_r == IDLE) && !reset) ? grant_oh_s : {PORT_NUM{1'b0}};

  reduce_and8 #(
    .WIDTH (WIDTH)
  ) u_reduce (
    .a (ops_r[7*WIDTH +: WIDTH]),
    .b (ops_r[6*WIDTH +: WIDTH]),
    .c (ops_r[5*WIDTH +: WIDTH]),
    .d (ops_r[4*WIDTH +: WIDTH]),
    .e (ops_r[3*WIDTH +: WIDTH]),
    .f (ops_r[2*WIDTH +: WIDTH]),
    .g (ops_r[1*WIDTH +: WIDTH]),
    .h (ops_r[0*WIDTH +: WIDTH]),
    .q (red_q_s)
  );

  // Control FSM with operand register and registered response channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      ops_r     <= '0;
      op_id_r   <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      rsp_id    <= '0;
`ifdef REDUCE_AND_ARB_RR_EN
      ptr_r     <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_any_s) begin
            ops_r   <= grant_data_s;
            op_id_r <= grant_idx_s;
            state_r <= EVAL;
`ifdef REDUCE_AND_ARB_RR_EN
            ptr_r   <= (grant_idx_s == ID_W'(PORT_NUM - 1)) ? '0 : (grant_idx_s + ID_W'(1));
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        EVAL: begin
          rsp_q     <= red_q_s;
          rsp_id    <= op_id_r;
          rsp_valid <= 1'b1;
          state_r   <= RESP;
        end
        RESP: begin
          // Hold the response until the consumer takes it.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r   <= RESP;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reduce_and_arbiter.sv
// Self-checking bench for reduce_and_arbiter (PORT_NUM=2, WIDTH=7) with a cycle-level behavioural model.
module tb_reduce_and_arbiter;

  localparam int PN  = 2;
  localparam int W   = 7;
  localparam int OPW = 8 * W;

  logic              clk;
  logic              reset;
  logic [PN-1:0]     req_valid;
  logic [PN-1:0]     req_ready;
  logic [PN*OPW-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_q;
  logic [0:0]        rsp_id;

  int n_chk  = 0;
  int n_pass = 0;

  reduce_and_arbiter #(.PORT_NUM(PN), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_q     (rsp_q),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: phase 0 = free, 1 = accepted (evaluating), 2 = response outstanding.
  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_id    = 0;
  logic        m_q     = 1'b0;
  int          cyc     = 0;
  int          log_id[$];
  int          log_cyc[$];

  function automatic int winner(input logic [PN-1:0] v, input int p);
    for (int k = 0; k < PN; k++) begin
      int i;
      i = (p + k) % PN;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_phase <= 0;
      m_ptr   <= 0;
    end else if (m_phase == 0) begin
      if (winner(req_valid, m_ptr) >= 0) begin
        m_id    <= winner(req_valid, m_ptr);
        m_q     <= &req_data[winner(req_valid, m_ptr)*OPW +: OPW];
`ifdef REDUCE_AND_ARB_RR_EN
        m_ptr   <= (winner(req_valid, m_ptr) + 1) % PN;
`endif
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      m_phase <= 2;
    end else if (rsp_ready) begin
      m_phase <= 0;
    end
  end

  // Compare DUT against the model every cycle on the falling edge.
  always @(negedge clk) begin
    logic [PN-1:0] er;
    er = '0;
    if (!reset && m_phase == 0 && winner(req_valid, m_ptr) >= 0) er[winner(req_valid, m_ptr)] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, (m_phase == 2));
    if (m_phase == 2) begin
      chk("rsp_q", rsp_q, {6'b0, m_q});
      chk("rsp_id", rsp_id, m_id);
    end
    chk("rsp_q_upper", rsp_q[W-1:1], 0);
    if (rsp_valid && rsp_ready) begin
      log_id.push_back(int'(rsp_id));
      log_cyc.push_back(cyc);
    end
  end

  task automatic at_drive();
    @(posedge clk);
    #2;
  endtask

  task automatic at_samp();
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic [OPW-1:0] d);
    req_data[p*OPW +: OPW] = d;
  endtask

  task automatic send(input int p, input logic [OPW-1:0] d);
    bit got;
    at_drive();
    set_port(p, d);
    req_valid[p] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      at_samp();
      got = req_ready[p];
    end
    chk("send_grant", got, 1);
    at_drive();
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_rsp();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      at_samp();
      got = rsp_valid;
    end
    chk("rsp_seen", got, 1);
  endtask

  logic [OPW-1:0] ones;
  logic [OPW-1:0] rnd;

  initial begin
    ones      = {8{7'h7F}};
    reset     = 1'b1;
    req_valid = 2'b11;
    req_data  = '0;
    rsp_ready = 1'b1;
    repeat (3) at_drive();
    at_samp();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_q", rsp_q, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_req_ready", req_ready, 2'b00);
    at_drive();
    reset     = 1'b0;
    req_valid = 2'b00;

    // All-ones operands on port 0.
    at_drive();
    set_port(0, ones);
    req_valid = 2'b01;
    at_samp();
    chk("t1_req_ready", req_ready, 2'b01);
    at_drive();
    req_valid = 2'b00;
    at_samp();
    chk("t1_valid_t1", rsp_valid, 0);
    at_samp();
    chk("t1_valid_t2", rsp_valid, 1);
    chk("t1_q", rsp_q, 7'h01);
    chk("t1_id", rsp_id, 0);
    repeat (3) at_drive();

    // Port 1 with a single zero bit in operand h.
    send(1, {{7{7'h7F}}, 7'h7E});
    wait_rsp();
    chk("t2_q", rsp_q, 7'h00);
    chk("t2_id", rsp_id, 1);
    repeat (3) at_drive();

    // Stall the response for several cycles.
    at_drive();
    set_port(0, ones);
    set_port(1, '0);
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    at_samp();
    chk("t4_req_ready", req_ready, 2'b01);
    at_drive();
    req_valid = 2'b11;
    at_samp();
    chk("t4_eval_ready", req_ready, 2'b00);
    for (int i = 0; i < 5; i++) begin
      at_samp();
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_q", rsp_q, 7'h01);
      chk("t4_hold_id", rsp_id, 0);
      chk("t4_hold_ready", req_ready, 2'b00);
    end
    at_drive();
    rsp_ready = 1'b1;
    at_samp();
    chk("t4_last_valid", rsp_valid, 1);
    at_samp();
    chk("t4_idle_valid", rsp_valid, 0);
`ifdef REDUCE_AND_ARB_RR_EN
    chk("t4_idle_ready", req_ready, 2'b10);
`else
    chk("t4_idle_ready", req_ready, 2'b01);
`endif
    at_drive();
    req_valid = 2'b00;
    repeat (5) at_drive();

    // Both ports held valid for 8 grants.
    log_id.delete();
    log_cyc.delete();
    at_drive();
    set_port(0, ones);
    set_port(1, '0);
    req_valid = 2'b11;
    for (int i = 0; i < 60 && log_id.size() < 8; i++) begin
      at_samp();
      #1;
    end
    at_drive();
    req_valid = 2'b00;
    chk("t3_count", (log_id.size() >= 8), 1);
    for (int i = 0; i < 8 && i < log_id.size(); i++) begin
`ifdef REDUCE_AND_ARB_RR_EN
      chk("t3_id_seq", log_id[i], i % 2);
`else
      chk("t3_id_seq", log_id[i], 0);
`endif
      if (i > 0) chk("t3_spacing", log_cyc[i] - log_cyc[i-1], 3);
    end
    repeat (5) at_drive();

    // Reset pulse during EVAL after a port 1 grant.
    at_drive();
    set_port(0, ones);
    set_port(1, ones);
    req_valid = 2'b10;
    at_samp();
    chk("t5_req_ready", req_ready, 2'b10);
    at_drive();
    reset     = 1'b1;
    req_valid = 2'b00;
    at_drive();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      at_samp();
      chk("t5_no_rsp", rsp_valid, 0);
    end
    at_drive();
    req_valid = 2'b11;
    at_samp();
    chk("t5_first_grant", req_ready, 2'b01);
    at_drive();
    req_valid = 2'b00;
    wait_rsp();
    chk("t5_id", rsp_id, 0);
    chk("t5_q", rsp_q, 7'h01);
    repeat (3) at_drive();

    // Random operands on random ports.
    log_id.delete();
    log_cyc.delete();
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < 8; k++)
        rnd[k*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 127)) : 7'h7F;
      send(int'($urandom_range(0, 1)), rnd);
    end
    repeat (6) at_drive();
    chk("t6_count", log_id.size(), 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
